// File: rtl/ext_pipe.sv
// ext_pipe: immediate / load-data extender feeding a DEPTH-entry result FIFO.
// Ports: clk, reset (async high), flush; in_valid/in_ready, extop, in_imm,
// in_data, in_off; out_valid/out_ready, out_data, out_err (head entry).
module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       extop,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [31:0]      in_data,
   input  logic [1:0]       in_off,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = OUT_W + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef logic [EW-1:0] entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [OUT_W-1:0] ext_data;
   logic            ext_err;
   logic            push, pop;
   entry_t          head;

   assign byte_sel = 8'(in_data >> {in_off, 3'b000});
   assign half_sel = 16'(in_data >> {in_off[1], 4'b0000});

   always_comb begin
      ext_data = '0;
      ext_err  = 1'b0;
      unique case (extop)
         3'b000: ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
         3'b001: ext_data = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
         3'b010: ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
         3'b011: ext_data = {{(OUT_W-8){byte_sel[7]}}, byte_sel};
         3'b100: ext_data = {{(OUT_W-8){1'b0}}, byte_sel};
         3'b101: begin
            if (in_off[0]) ext_err = 1'b1;
            else ext_data = {{(OUT_W-16){half_sel[15]}}, half_sel};
         end
         3'b110: begin
            if (in_off[0]) ext_err = 1'b1;
            else ext_data = {{(OUT_W-16){1'b0}}, half_sel};
         end
         default: ext_err = 1'b1;
      endcase
   end

   // Status comes only from the registered count, never from the handshakes.
   assign out_valid = (count_q != '0);
   assign in_ready  = (count_q != CNT_FULL);

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {ext_err, ext_data};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push && !pop) count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Stale entries remain in storage after a flush, so gate by occupancy.
   assign head     = mem_q[rd_ptr_q];
   assign out_data = out_valid ? head[OUT_W-1:0] : '0;
   assign out_err  = out_valid & head[OUT_W];

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed self-checking bench for ext_pipe (defaults).
// Drives at #1 after posedge, samples at #1 after posedge.
module tb_ext_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  extop;
   logic [15:0] in_imm;
   logic [31:0] in_data;
   logic [1:0]  in_off;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .extop(extop), .in_imm(in_imm), .in_data(in_data), .in_off(in_off),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err)
   );

   task automatic put(input logic [2:0] op, input logic [15:0] imm,
                      input logic [31:0] dat, input logic [1:0] off);
      extop   = op;
      in_imm  = imm;
      in_data = dat;
      in_off  = off;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      put(3'b000, 16'h0, 32'h0, 2'd0);
      #2;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0
          || in_ready !== 1'b1) begin
         $display("FAIL reset_state v=%b d=%h e=%b r=%b want 0 0 0 1",
                  out_valid, out_data, out_err, in_ready);
         n_fail++;
      end
      n_cmp++;
      step(); step();
      reset = 1'b0;
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL reset_release v=%b r=%b want 0 1", out_valid, in_ready);
         n_fail++;
      end
      n_cmp++;
   endtask

   // Back-to-back accepts with out_ready high; each result is head
   // right after its accept edge.
   task automatic test_modes();
      logic [2:0]  ops [11];
      logic [15:0] imms[11];
      logic [31:0] dats[11];
      logic [1:0]  offs[11];
      logic [31:0] exp_d[11];
      logic        exp_e[11];
      ops  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110,
               3'b101, 3'b111, 3'b001, 3'b011};
      imms = '{16'h8001, 16'h8001, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0,
               16'h0, 16'h1234, 16'h7FFF, 16'h0};
      dats = '{32'h0, 32'h0, 32'h0, 32'h80FF7F01, 32'h80FF7F01,
               32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'hFFFFFFFF,
               32'h0, 32'h80FF7F01};
      offs = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0,
               2'd0, 2'd1};
      exp_d = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFFFFFF,
                32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0, 32'h0,
                32'h00007FFF, 32'h0000007F};
      exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         put(ops[i], imms[i], dats[i], offs[i]);
         in_valid = 1'b1;
         step();
         if (out_valid !== 1'b1 || out_data !== exp_d[i]
             || out_err !== exp_e[i]) begin
            $display("FAIL mode_%0d v=%b d=%h e=%b want 1 %h %b", i,
                     out_valid, out_data, out_err, exp_d[i], exp_e[i]);
            n_fail++;
         end
         n_cmp++;
      end
      in_valid = 1'b0;
      step();
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         $display("FAIL modes_drain v=%b d=%h want 0 0", out_valid, out_data);
         n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      put(3'b000, 16'h000A, 32'h0, 2'd0); in_valid = 1'b1;
      step();
      if (in_ready !== 1'b1 || out_data !== 32'h0000000A) begin
         $display("FAIL bp_first r=%b d=%h want 1 0000000a", in_ready, out_data);
         n_fail++;
      end
      n_cmp++;
      put(3'b000, 16'h000B, 32'h0, 2'd0);
      step();
      if (in_ready !== 1'b0 || out_data !== 32'h0000000A) begin
         $display("FAIL bp_full r=%b d=%h want 0 0000000a", in_ready, out_data);
         n_fail++;
      end
      n_cmp++;
      put(3'b000, 16'h000C, 32'h0, 2'd0);
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1
          || out_data !== 32'h0000000A) begin
         $display("FAIL bp_hold r=%b v=%b d=%h want 0 1 0000000a",
                  in_ready, out_valid, out_data);
         n_fail++;
      end
      n_cmp++;
      out_ready = 1'b1;
      step();
      if (in_ready !== 1'b1 || out_data !== 32'h0000000B) begin
         $display("FAIL bp_pop1 r=%b d=%h want 1 0000000b", in_ready, out_data);
         n_fail++;
      end
      n_cmp++;
      step();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_data !== 32'h0000000C) begin
         $display("FAIL bp_pop2 v=%b d=%h want 1 0000000c", out_valid, out_data);
         n_fail++;
      end
      n_cmp++;
      step();
      if (out_valid !== 1'b0) begin
         $display("FAIL bp_empty v=%b want 0", out_valid);
         n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      put(3'b000, 16'h0011, 32'h0, 2'd0); in_valid = 1'b1;
      step();
      put(3'b000, 16'h0022, 32'h0, 2'd0);
      step();
      put(3'b000, 16'h0033, 32'h0, 2'd0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
         $display("FAIL flush_state v=%b r=%b d=%h want 0 1 0",
                  out_valid, in_ready, out_data);
         n_fail++;
      end
      n_cmp++;
      out_ready = 1'b1;
      step();
      if (out_valid !== 1'b0) begin
         $display("FAIL flush_dropped v=%b want 0", out_valid);
         n_fail++;
      end
      n_cmp++;
      put(3'b001, 16'hF000, 32'h0, 2'd0); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFFF000) begin
         $display("FAIL flush_after v=%b d=%h want 1 fffff000",
                  out_valid, out_data);
         n_fail++;
      end
      n_cmp++;
      step();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      put(3'b010, 16'h00FF, 32'h0, 2'd0); in_valid = 1'b1;
      step();
      put(3'b000, 16'h0044, 32'h0, 2'd0);
      step();
      #2;
      reset = 1'b1;
      #1;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0
          || in_ready !== 1'b1) begin
         $display("FAIL async_reset v=%b d=%h e=%b r=%b want 0 0 0 1",
                  out_valid, out_data, out_err, in_ready);
         n_fail++;
      end
      n_cmp++;
      in_valid = 1'b0;
      step();
      #2;
      reset = 1'b0;
      #1;
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         $display("FAIL reset_clean v=%b d=%h want 0 0", out_valid, out_data);
         n_fail++;
      end
      n_cmp++;
      step();
      out_ready = 1'b1;
      put(3'b100, 16'h0, 32'h12345678, 2'd1); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_data !== 32'h00000056
          || out_err !== 1'b0) begin
         $display("FAIL post_reset v=%b d=%h e=%b want 1 00000056 0",
                  out_valid, out_data, out_err);
         n_fail++;
      end
      n_cmp++;
      step();
      if (out_valid !== 1'b0) begin
         $display("FAIL no_stale v=%b want 0", out_valid);
         n_fail++;
      end
      n_cmp++;
   endtask

   initial begin
      test_reset();
      test_modes();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
